bram_port_arb: RTL and testbench
================================

BRAM_PORT_ARB -- requirements
Module: bram_port_arb

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 14, BRAM address width; BUF_NUM, default 16, bank chip-select width; RD_LAT, default 1, BRAM read latency in cycles.
REQ-002 SHALL have one clock and an asynchronous active-low reset, listed first: i_clk  in  1  clock; i_rstn  in  1  async active-low reset.
REQ-003 SHALL have abort port: i_abort  in  1  synchronous abort of the current burst.
REQ-004 SHALL have writer (DMA fill) ports, where x = wr: i_x_req  in  1  burst request; i_x_vld  in  1  beat valid; i_x_last  in  1  final beat, qualified by vld; i_x_addr  in  ADDR_WIDTH  beat address; i_x_cs  in  BUF_NUM  one-hot bank select; o_x_gnt  out  1  burst grant.
REQ-005 SHALL have the same six reader ports for x = rd0 (conv_00 engine) and x = rd1 (conv_02 engine).
REQ-006 SHALL have reader return ports: o_rd0_dvld  out  1  read data valid for rd0; o_rd1_dvld  out  1  read data valid for rd1.
REQ-007 SHALL have BRAM ports: o_bram_en  out  1; o_bram_we  out  1; o_bram_cs  out  BUF_NUM; o_bram_addr  out  ADDR_WIDTH.

Function
REQ-008 SHALL implement the FSM states ST_IDLE, ST_WR, ST_RD0 and ST_RD1, with exactly one grant high in each non-idle state.
REQ-009 SHALL arbitrate only in ST_IDLE; the registered grant SHALL go high the cycle after the winning request is sampled.
REQ-010 SHALL give the writer priority over the readers; between rd0 and rd1, priority SHALL be round-robin, with the last-served reader becoming lowest priority.
REQ-011 SHALL lock the grant for the whole burst; no other requester SHALL be granted until a beat with vld&last is accepted or i_abort occurs.
REQ-012 SHALL accept a beat on a cycle where gnt&vld is true; the BRAM outputs for that beat SHALL be registered and driven in the next cycle: en=1, cs=i_x_cs, addr=i_x_addr, we=1 only for the writer.
REQ-013 SHALL hold en, we and cs at 0 on any cycle with no accepted beat in the prior cycle.
REQ-014 SHALL assert o_rdX_dvld exactly 1+RD_LAT cycles after an accepted read beat, for the reader that issued the beat, using a tag shift pipeline.
REQ-015 SHALL return to ST_IDLE on the cycle a last beat is accepted; the grant SHALL drop the next cycle, with one idle arbitration cycle before the next grant.
REQ-016 SHALL treat i_x_req low during a burst as no effect; only last or abort ends the burst.
REQ-017 SHALL ignore i_x_vld from non-granted requesters entirely.
REQ-018 SHALL, on i_abort, enter ST_IDLE next cycle, drop all grants, and suppress both the BRAM outputs and the dvld pipeline.
REQ-019 SHALL give i_abort precedence over a simultaneous last beat.
REQ-020 SHALL treat a one-cycle burst (vld&last on the first granted cycle) as valid.

Reset
REQ-021 SHALL, on i_rstn low, asynchronously enter ST_IDLE and clear all grants, o_bram_* outputs, dvld outputs, the tag pipeline and the round-robin pointer (rd0 first).
REQ-022 SHALL discard all in-flight beats when reset is asserted mid-burst.

Configuration
REQ-023 SHALL provide the macro BRAM_ARB_STARVE_GUARD_EN: when defined, once a writer burst completes and any reader request is pending, a reader SHALL be granted before the writer is granted again; when undefined, the writer SHALL have strict priority.

Structure
REQ-024 SHALL place the state encodings (ST_IDLE, ST_WR, ST_RD0, ST_RD1) and requester index constants (REQ_WR=0, REQ_RD0=1, REQ_RD1=2) in the shared package bram_pkg.
REQ-025 SHALL contain one sub-module, bram_rd_tag_pipe, implementing the RD_LAT+1-deep valid/tag shift register that generates o_rd0_dvld and o_rd1_dvld.

Verification
REQ-026 SHALL cover this scenario: wr_req and rd0_req in the same cycle -> wr_gnt=1 next cycle; a 4-beat write gives we=1 for 4 cycles; rd0_gnt=1 two cycles after the last beat.
REQ-027 SHALL cover this scenario: rd0 and rd1 requesting continuously with 2-beat bursts -> grants alternate rd0, rd1, rd0, rd1; o_rdX_dvld is high 2 cycles after each accepted beat (RD_LAT=1).
REQ-028 SHALL cover this scenario: beat with addr=0x1234, cs=0x0080 -> o_bram_addr=0x1234 and o_bram_cs=0x0080 exactly one cycle later, with en=1.
REQ-029 SHALL cover this scenario: i_abort on the same cycle as rd1 vld&last -> no o_bram_en, no o_rd1_dvld, and all grants 0 next cycle.
REQ-030 SHALL cover this scenario: wr_req held high and rd1 requesting -> with the macro defined, rd1 is granted after every writer burst; without it, rd1 is never granted.
REQ-031 SHALL cover this scenario: i_rstn low mid-write burst -> all outputs 0 immediately, ST_IDLE, and rd0 as round-robin head after release.

Source files
------------

// File: rtl/bram_pkg.sv
// Shared encodings for the BRAM port arbiter: FSM states and requester indices.
package bram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD0  = 2'd2,
    ST_RD1  = 2'd3
  } state_t;

  localparam int REQ_WR  = 0;
  localparam int REQ_RD0 = 1;
  localparam int REQ_RD1 = 2;
  localparam int NUM_REQ = 3;

endpackage

// File: rtl/bram_rd_tag_pipe.sv
// Valid/tag shift register, RD_LAT+1 stages deep, that turns accepted read
// beats into per-reader data-valid strobes aligned with the BRAM read data.
module bram_rd_tag_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_flush,
  input  logic i_vld,
  input  logic i_tag,
  output logic o_rd0_dvld,
  output logic o_rd1_dvld
);

  localparam int DEPTH = RD_LAT + 1;

  logic [DEPTH-1:0] r_vld;
  logic [DEPTH-1:0] r_tag;

  // Tag 0 marks a beat from rd0, tag 1 a beat from rd1.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_vld <= '0;
      r_tag <= '0;
    end else if (i_flush) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= i_vld;
      r_tag[0] <= i_tag;
      for (int k = 1; k < DEPTH; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_tag[k] <= r_tag[k-1];
      end
    end
  end

  assign o_rd0_dvld = r_vld[DEPTH-1] & ~r_tag[DEPTH-1];
  assign o_rd1_dvld = r_vld[DEPTH-1] &  r_tag[DEPTH-1];

endmodule

// File: rtl/bram_port_arb.sv
// Three-requester burst arbiter (DMA writer + two conv readers) in front of one BRAM port.
// Optional macro BRAM_ARB_STARVE_GUARD_EN: after a writer burst, a pending reader goes first.
module bram_port_arb
  import bram_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int BUF_NUM    = 16,
  parameter int RD_LAT     = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_abort,
  input  logic                  i_wr_req,
  input  logic                  i_wr_vld,
  input  logic                  i_wr_last,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [BUF_NUM-1:0]    i_wr_cs,
  output logic                  o_wr_gnt,
  input  logic                  i_rd0_req,
  input  logic                  i_rd0_vld,
  input  logic                  i_rd0_last,
  input  logic [ADDR_WIDTH-1:0] i_rd0_addr,
  input  logic [BUF_NUM-1:0]    i_rd0_cs,
  output logic                  o_rd0_gnt,
  input  logic                  i_rd1_req,
  input  logic                  i_rd1_vld,
  input  logic                  i_rd1_last,
  input  logic [ADDR_WIDTH-1:0] i_rd1_addr,
  input  logic [BUF_NUM-1:0]    i_rd1_cs,
  output logic                  o_rd1_gnt,
  output logic                  o_rd0_dvld,
  output logic                  o_rd1_dvld,
  output logic                  o_bram_en,
  output logic                  o_bram_we,
  output logic [BUF_NUM-1:0]    o_bram_cs,
  output logic [ADDR_WIDTH-1:0] o_bram_addr
);

  state_t                r_state;
  logic                  r_wr_gnt, r_rd0_gnt, r_rd1_gnt;
  logic                  r_rd1_prio;
  logic                  r_en, r_we;
  logic [BUF_NUM-1:0]    r_cs;
  logic [ADDR_WIDTH-1:0] r_addr;

  logic [NUM_REQ-1:0]    w_req;
  logic                  w_vld, w_last, w_acc, w_done, w_wr_ok, w_rd_beat;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [BUF_NUM-1:0]    w_cs;
  state_t                w_arb;

  assign w_req[REQ_WR]  = i_wr_req;
  assign w_req[REQ_RD0] = i_rd0_req;
  assign w_req[REQ_RD1] = i_rd1_req;

  // Only the burst owner's beat signals are looked at; everyone else is ignored.
  always_comb begin
    w_vld  = 1'b0;
    w_last = 1'b0;
    w_addr = '0;
    w_cs   = '0;
    case (r_state)
      ST_WR:   begin w_vld = i_wr_vld;  w_last = i_wr_last;  w_addr = i_wr_addr;  w_cs = i_wr_cs;  end
      ST_RD0:  begin w_vld = i_rd0_vld; w_last = i_rd0_last; w_addr = i_rd0_addr; w_cs = i_rd0_cs; end
      ST_RD1:  begin w_vld = i_rd1_vld; w_last = i_rd1_last; w_addr = i_rd1_addr; w_cs = i_rd1_cs; end
      default: ;
    endcase
  end

  assign w_acc     = w_vld & ~i_abort;
  assign w_done    = w_acc & w_last;
  assign w_rd_beat = w_acc & ((r_state == ST_RD0) || (r_state == ST_RD1));

`ifdef BRAM_ARB_STARVE_GUARD_EN
  logic r_wr_owed;

  // Set when a writer burst ends; cleared by the next grant of any kind.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)
      r_wr_owed <= 1'b0;
    else if ((r_state == ST_WR) && (i_abort || w_done))
      r_wr_owed <= 1'b1;
    else if ((r_state == ST_IDLE) && !i_abort && (w_arb != ST_IDLE))
      r_wr_owed <= 1'b0;
  end

  assign w_wr_ok = w_req[REQ_WR] & ~(r_wr_owed & (w_req[REQ_RD0] | w_req[REQ_RD1]));
`else
  assign w_wr_ok = w_req[REQ_WR];
`endif

  always_comb begin
    w_arb = ST_IDLE;
    if (w_wr_ok)
      w_arb = ST_WR;
    else if (w_req[REQ_RD0] && (!w_req[REQ_RD1] || !r_rd1_prio))
      w_arb = ST_RD0;
    else if (w_req[REQ_RD1])
      w_arb = ST_RD1;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state    <= ST_IDLE;
      r_wr_gnt   <= 1'b0;
      r_rd0_gnt  <= 1'b0;
      r_rd1_gnt  <= 1'b0;
      r_rd1_prio <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!i_abort && (w_arb != ST_IDLE)) begin
            r_state   <= w_arb;
            r_wr_gnt  <= (w_arb == ST_WR);
            r_rd0_gnt <= (w_arb == ST_RD0);
            r_rd1_gnt <= (w_arb == ST_RD1);
            if (w_arb == ST_RD0) r_rd1_prio <= 1'b1;
            if (w_arb == ST_RD1) r_rd1_prio <= 1'b0;
          end
        end
        default: begin
          if (i_abort || w_done) begin
            r_state   <= ST_IDLE;
            r_wr_gnt  <= 1'b0;
            r_rd0_gnt <= 1'b0;
            r_rd1_gnt <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_en   <= 1'b0;
      r_we   <= 1'b0;
      r_cs   <= '0;
      r_addr <= '0;
    end else begin
      r_en <= w_acc;
      r_we <= w_acc & (r_state == ST_WR);
      r_cs <= w_acc ? w_cs : '0;
      if (w_acc) r_addr <= w_addr;
    end
  end

  bram_rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_flush    (i_abort),
    .i_vld      (w_rd_beat),
    .i_tag      (r_state == ST_RD1),
    .o_rd0_dvld (o_rd0_dvld),
    .o_rd1_dvld (o_rd1_dvld)
  );

  assign o_wr_gnt    = r_wr_gnt;
  assign o_rd0_gnt   = r_rd0_gnt;
  assign o_rd1_gnt   = r_rd1_gnt;
  assign o_bram_en   = r_en;
  assign o_bram_we   = r_we;
  assign o_bram_cs   = r_cs;
  assign o_bram_addr = r_addr;

endmodule

// File: tb/tb_bram_port_arb.sv
// Bench for bram_port_arb: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a burst-level reference model.
module tb_bram_port_arb;

  localparam int AW     = 14;
  localparam int BN     = 16;
  localparam int RD_LAT = 1;
`ifdef BRAM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0, rstn = 1'b0, abort = 1'b0;
  logic wr_req = 0, wr_vld = 0, wr_last = 0;
  logic rd0_req = 0, rd0_vld = 0, rd0_last = 0;
  logic rd1_req = 0, rd1_vld = 0, rd1_last = 0;
  logic [AW-1:0] wr_addr = '0, rd0_addr = '0, rd1_addr = '0;
  logic [BN-1:0] wr_cs = '0, rd0_cs = '0, rd1_cs = '0;
  logic wr_gnt, rd0_gnt, rd1_gnt, rd0_dvld, rd1_dvld, en, we;
  logic [BN-1:0] cs;
  logic [AW-1:0] addr;

  always #5 clk = ~clk;

  bram_port_arb #(.ADDR_WIDTH(AW), .BUF_NUM(BN), .RD_LAT(RD_LAT)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_abort(abort),
    .i_wr_req(wr_req), .i_wr_vld(wr_vld), .i_wr_last(wr_last),
    .i_wr_addr(wr_addr), .i_wr_cs(wr_cs), .o_wr_gnt(wr_gnt),
    .i_rd0_req(rd0_req), .i_rd0_vld(rd0_vld), .i_rd0_last(rd0_last),
    .i_rd0_addr(rd0_addr), .i_rd0_cs(rd0_cs), .o_rd0_gnt(rd0_gnt),
    .i_rd1_req(rd1_req), .i_rd1_vld(rd1_vld), .i_rd1_last(rd1_last),
    .i_rd1_addr(rd1_addr), .i_rd1_cs(rd1_cs), .o_rd1_gnt(rd1_gnt),
    .o_rd0_dvld(rd0_dvld), .o_rd1_dvld(rd1_dvld),
    .o_bram_en(en), .o_bram_we(we), .o_bram_cs(cs), .o_bram_addr(addr)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner 0=none 1=wr 2=rd0 3=rd1; read strobes scheduled by cycle number.
  int            cyc = 0;
  int            m_owner = 0;
  bit            m_rd1_next = 0, m_owed = 0;
  bit            e_en = 0, e_we = 0;
  logic [BN-1:0] e_cs = '0;
  logic [AW-1:0] e_addr = '0;
  bit            sched0[int];
  bit            sched1[int];

  initial forever begin
    bit            b_vld, b_last;
    logic [AW-1:0] b_addr;
    logic [BN-1:0] b_cs;
    int            win;
    @(posedge clk or negedge rstn);
    if (!rstn) begin
      m_owner = 0; m_rd1_next = 0; m_owed = 0;
      e_en = 0; e_we = 0; e_cs = '0; e_addr = '0;
      sched0.delete(); sched1.delete();
    end else begin
      cyc++;
      e_en = 0; e_we = 0; e_cs = '0;
      if (abort) begin
        if (m_owner == 1) m_owed = 1;
        m_owner = 0;
        for (int k = 0; k <= RD_LAT; k++) begin
          sched0.delete(cyc + k);
          sched1.delete(cyc + k);
        end
      end else if (m_owner != 0) begin
        b_vld = 0; b_last = 0; b_addr = '0; b_cs = '0;
        if (m_owner == 1) begin b_vld = wr_vld;  b_last = wr_last;  b_addr = wr_addr;  b_cs = wr_cs;  end
        if (m_owner == 2) begin b_vld = rd0_vld; b_last = rd0_last; b_addr = rd0_addr; b_cs = rd0_cs; end
        if (m_owner == 3) begin b_vld = rd1_vld; b_last = rd1_last; b_addr = rd1_addr; b_cs = rd1_cs; end
        if (b_vld) begin
          e_en = 1; e_we = (m_owner == 1); e_cs = b_cs; e_addr = b_addr;
          if (m_owner == 2) sched0[cyc + RD_LAT] = 1;
          if (m_owner == 3) sched1[cyc + RD_LAT] = 1;
          if (b_last) begin
            if (m_owner == 1) m_owed = 1;
            m_owner = 0;
          end
        end
      end else begin
        win = 0;
        if (wr_req && !(GUARD && m_owed && (rd0_req || rd1_req))) win = 1;
        else if (rd0_req && rd1_req) win = m_rd1_next ? 3 : 2;
        else if (rd0_req) win = 2;
        else if (rd1_req) win = 3;
        if (win != 0) m_owed = 0;
        if (win == 2) m_rd1_next = 1;
        if (win == 3) m_rd1_next = 0;
        m_owner = win;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("wr_gnt",   wr_gnt,   (m_owner == 1));
      chk("rd0_gnt",  rd0_gnt,  (m_owner == 2));
      chk("rd1_gnt",  rd1_gnt,  (m_owner == 3));
      chk("bram_en",  en,       e_en);
      chk("bram_we",  we,       e_we);
      chk("bram_cs",  cs,       e_cs);
      if (e_en) chk("bram_addr", addr, e_addr);
      chk("rd0_dvld", rd0_dvld, sched0.exists(cyc));
      chk("rd1_dvld", rd1_dvld, sched1.exists(cyc));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    abort = 0;
    wr_req = 0;  wr_vld = 0;  wr_last = 0;
    rd0_req = 0; rd0_vld = 0; rd0_last = 0;
    rd1_req = 0; rd1_vld = 0; rd1_last = 0;
  endtask

  int we_cnt, gnt_cnt;

  initial begin
    clr();
    rstn = 0;
    repeat (3) tick();
    chk("rst_gnts", {wr_gnt, rd0_gnt, rd1_gnt}, 3'b000);
    chk("rst_en_we", {en, we}, 2'b00);
    chk("rst_cs", cs, 16'h0000);
    rstn = 1;
    chk_en = 1;
    tick();

    // Writer wins a tie, 4-beat write, reader follows after one idle cycle.
    wr_req = 1; rd0_req = 1;
    tick();
    chk("s26_first_gnt", {wr_gnt, rd0_gnt}, 2'b10);
    wr_req = 0;
    we_cnt = 0;
    for (int b = 0; b < 4; b++) begin
      wr_vld = 1; wr_last = (b == 3); wr_addr = AW'(b); wr_cs = 16'(1) << b;
      tick();
      we_cnt += int'(we);
    end
    wr_vld = 0; wr_last = 0;
    chk("s26_we_beats", we_cnt, 4);
    chk("s26_wr_gnt_drop", wr_gnt, 0);
    tick();
    chk("s26_rd0_gnt", rd0_gnt, 1);
    $display("txn: write burst 4 beats then rd0 grant");
    rd0_req = 0; rd0_vld = 1; rd0_last = 1;
    tick();
    clr();
    repeat (2) tick();

    // Single-beat read: address/cs registered one cycle later, dvld 1+RD_LAT later.
    rd1_req = 1;
    tick();
    chk("s28_rd1_gnt", rd1_gnt, 1);
    rd1_req = 0; rd1_vld = 1; rd1_last = 1; rd1_addr = 14'h1234; rd1_cs = 16'h0080;
    tick();
    chk("s28_addr", addr, 32'h1234);
    chk("s28_cs", cs, 32'h0080);
    chk("s28_en_we", {en, we}, 2'b10);
    clr();
    tick();
    chk("s28_dvld", {rd0_dvld, rd1_dvld}, 2'b01);
    chk("s28_en_off", en, 0);
    $display("txn: rd1 beat addr=1234 cs=0080");
    repeat (2) tick();

    // Abort beats a simultaneous last beat.
    rd1_req = 1;
    tick();
    chk("s29_rd1_gnt", rd1_gnt, 1);
    rd1_vld = 1; rd1_last = 1; abort = 1;
    tick();
    chk("s29_en", en, 0);
    chk("s29_gnts", {wr_gnt, rd0_gnt, rd1_gnt}, 3'b000);
    clr();
    tick();
    chk("s29_dvld", rd1_dvld, 0);
    $display("txn: abort with rd1 last beat");
    repeat (2) tick();

    // Two readers with 2-beat bursts alternate.
    rd0_req = 1; rd1_req = 1;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("s27_gnt_order", {rd0_gnt, rd1_gnt}, (k % 2 == 0) ? 2'b10 : 2'b01);
      if (k % 2 == 0) begin rd0_vld = 1; rd0_last = 0; rd0_addr = AW'($urandom); rd0_cs = 16'h0001; end
      else            begin rd1_vld = 1; rd1_last = 0; rd1_addr = AW'($urandom); rd1_cs = 16'h0002; end
      tick();
      rd0_last = rd0_vld; rd1_last = rd1_vld;
      tick();
      chk("s27_dvld", (k % 2 == 0) ? rd0_dvld : rd1_dvld, 1);
      rd0_vld = 0; rd0_last = 0; rd1_vld = 0; rd1_last = 0;
      tick();
      $display("txn: reader burst %0d granted to rd%0d", k, k % 2);
    end
    clr();
    repeat (3) tick();

    // Writer hogging the port while rd1 waits.
    wr_req = 1; wr_vld = 1; wr_last = 1;
    rd1_req = 1; rd1_vld = 1; rd1_last = 1;
    gnt_cnt = 0;
    repeat (40) begin
      tick();
      gnt_cnt += int'(rd1_gnt);
    end
    clr();
    chk("s30_rd1_served", (gnt_cnt > 0), GUARD);
    $display("txn: writer hog, rd1 grant cycles=%0d", gnt_cnt);
    repeat (3) tick();

    // Reset mid-write restores idle and rd0-first round robin.
    rd0_req = 1;
    tick();
    rd0_req = 0; rd0_vld = 1; rd0_last = 1;
    tick();
    clr();
    repeat (2) tick();
    wr_req = 1;
    tick();
    chk("s31_wr_gnt", wr_gnt, 1);
    wr_req = 0; wr_vld = 1; wr_last = 0; wr_cs = 16'h8000;
    tick();
    chk("s31_we", we, 1);
    #2;
    rstn = 0;
    #1;
    chk("s31_rst_gnts", {wr_gnt, rd0_gnt, rd1_gnt}, 3'b000);
    chk("s31_rst_bram", {en, we, rd0_dvld, rd1_dvld}, 4'b0000);
    chk("s31_rst_cs", cs, 0);
    clr();
    @(negedge clk);
    rstn = 1;
    rd0_req = 1; rd1_req = 1;
    tick();
    chk("s31_rr_head", {rd0_gnt, rd1_gnt}, 2'b10);
    $display("txn: reset mid write, rd0 granted after release");
    rd0_req = 0; rd1_req = 0; rd0_vld = 1; rd0_last = 1;
    tick();
    clr();
    repeat (3) tick();

    // Randomized traffic, checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      wr_req   = ($urandom_range(0, 99) < 35);
      rd0_req  = ($urandom_range(0, 99) < 50);
      rd1_req  = ($urandom_range(0, 99) < 50);
      wr_vld   = ($urandom_range(0, 99) < 60);
      rd0_vld  = ($urandom_range(0, 99) < 60);
      rd1_vld  = ($urandom_range(0, 99) < 60);
      wr_last  = ($urandom_range(0, 99) < 30);
      rd0_last = ($urandom_range(0, 99) < 30);
      rd1_last = ($urandom_range(0, 99) < 30);
      wr_addr  = AW'($urandom); rd0_addr = AW'($urandom); rd1_addr = AW'($urandom);
      wr_cs    = 16'(1) << $urandom_range(0, 15);
      rd0_cs   = 16'(1) << $urandom_range(0, 15);
      rd1_cs   = 16'(1) << $urandom_range(0, 15);
      abort    = ($urandom_range(0, 99) < 3);
      tick();
    end
    clr();
    repeat (5) tick();
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
